// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM state type and access-size helper shared by the load/store unit files
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, RMW_WRITE, STORE, RESP} state_t;
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    return funct3[1:0] == 2'b00 ? 3'd1 : funct3[1:0] == 2'b01 ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: request/response handshake plus word-wide data-memory bus; master = load/store unit, slave = CPU stage and memory
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_load;
  logic        mem_store;
  logic        mem_pulse;
  logic [31:0] mem_read_data;
  modport master (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
           mem_address, mem_write_data, mem_load, mem_store, mem_pulse
  );
  modport slave (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           mem_address, mem_write_data, mem_load, mem_store, mem_pulse
  );
endinterface

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: load lane extract/extend and SB/SH lane merge; in word/addr/funct3/wdata, out load_val/merged
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);
  logic [4:0]  sh;
  logic [7:0]  b;
  logic [15:0] h;
  assign sh = {addr, 3'b000};
  assign b = 8'(word >> sh);
  assign h = addr[1] ? word[31:16] : word[15:0];
  assign load_val = funct3 == F3_B  ? {{24{b[7]}}, b}  :
                    funct3 == F3_H  ? {{16{h[15]}}, h} :
                    funct3 == F3_BU ? {24'd0, b}       :
                    funct3 == F3_HU ? {16'd0, h}       : word;
  assign merged = funct3[0] ? (addr[1] ? {wdata, word[15:0]} : {word[31:16], wdata})
                            : (word & ~(32'hFF << sh)) | ({24'd0, wdata[7:0]} << sh);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory initiator with SB/SH read-modify-write; ports clk, reset, lsu_if.master bus
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 32
) (
  input logic   clk,
  input logic   reset,
  lsu_if.master bus
);
  state_t      state, next_state;
  logic        is_store_q, err_q, accept, legal, req_err;
  logic [2:0]  f3_q, size;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q, word_q, addr_q, load_val, merged;
  assign accept = bus.req_valid && state == IDLE;
  assign size = access_size(bus.req_funct3);
  assign legal = bus.req_is_store ? bus.req_funct3 inside {F3_B, F3_H, F3_W}
                                  : bus.req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  // range test in 33 bits so addresses near 2^32 cannot wrap into range
  assign req_err = !legal || (size == 3'd2 && bus.req_addr[0]) ||
                   (size == 3'd4 && bus.req_addr[1:0] != 2'b00) ||
                   ({1'b0, bus.req_addr} + 33'(size) > 33'(MEM_BYTES));
  always_ff @(posedge clk) state <= reset ? IDLE : next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:                   if (accept) next_state = req_err ? RESP : !bus.req_is_store ? LOAD :
                                                       bus.req_funct3 == F3_W ? STORE : RMW_READ;
      LOAD, STORE, RMW_WRITE: next_state = RESP;
      RMW_READ:               next_state = RMW_WRITE;
      default:                next_state = IDLE;
    endcase
  end
  always_comb begin
    bus.req_ready      = state == IDLE;
    bus.mem_load       = state inside {LOAD, RMW_READ};
    bus.mem_store      = state inside {RMW_WRITE, STORE};
    bus.mem_pulse      = state inside {LOAD, RMW_READ, RMW_WRITE, STORE};
    bus.mem_write_data = state == STORE ? wdata_q : state == RMW_WRITE ? merged : '0;
    bus.mem_address    = addr_q;
    bus.resp_valid     = state == RESP;
    bus.resp_error     = state == RESP && err_q;
    bus.resp_rdata     = state == RESP && !err_q && !is_store_q ? load_val : '0;
  end
  // mem_address only moves for accesses that will actually pulse the memory
  always_ff @(posedge clk)
    if (reset) begin
      is_store_q <= 1'b0;
      err_q      <= 1'b0;
      f3_q       <= '0;
      lane_q     <= '0;
      wdata_q    <= '0;
      word_q     <= '0;
      addr_q     <= '0;
    end else if (accept) begin
      is_store_q <= bus.req_is_store;
      err_q      <= req_err;
      f3_q       <= bus.req_funct3;
      lane_q     <= bus.req_addr[1:0];
      wdata_q    <= bus.req_wdata;
      if (!req_err) addr_q <= {bus.req_addr[31:2], 2'b00};
    end else if (state inside {LOAD, RMW_READ}) word_q <= bus.mem_read_data;
  lsu_byte_lane u_lane (
    .word     (word_q),
    .addr     (lane_q),
    .funct3   (f3_q),
    .wdata    (wdata_q[15:0]),
    .load_val (load_val),
    .merged   (merged)
  );
endmodule
